// File: rtl/ssp_rx_ctrl_pkg.sv
// Shared types and defaults for the SSP receive sequencer.
package ssp_rx_ctrl_pkg;

  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned CNT_W_DEF       = $clog2(DATA_W_DEF);

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_e;

  // Bit-counter width for a given frame width (never narrower than one bit).
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/ssp_rx_ctrl_if.sv
// Link-side lines and RxFIFO-side handshake of the SSP receive sequencer.
interface ssp_rx_ctrl_if
  import ssp_rx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              rxen;
  logic              sspclkin;
  logic              sspfssin;
  logic              ssprxd;
  logic              rxfull;
  logic              ovr_clr;
  logic              rcv;
  logic [DATA_W-1:0] rxdata;
  logic              rxoverrun;
  logic              rxbusy;

  // Environment side: pins, FIFO status and control.
  modport master (
    output rxen, sspclkin, sspfssin, ssprxd, rxfull, ovr_clr,
    input  rcv, rxdata, rxoverrun, rxbusy
  );

  // Receive sequencer side.
  modport slave (
    input  rxen, sspclkin, sspfssin, ssprxd, rxfull, ovr_clr,
    output rcv, rxdata, rxoverrun, rxbusy
  );

endinterface

// File: rtl/ssp_rx_ctrl_edge_sync.sv
// Synchronises the three link lines into pclk and detects falling edges of sspclkin.
module ssp_rx_ctrl_edge_sync
  import ssp_rx_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic pclk,
  input  logic clear_b,
  input  logic sspclkin,
  input  logic sspfssin,
  input  logic ssprxd,
  output logic fall,
  output logic fss_s,
  output logic rxd_s
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] fss_sync;
  logic [SYNC_STAGES-1:0] rxd_sync;
  logic                   clk_prev;

  // Equal-depth chains so data and sync line up with the detected clock edge.
  always_ff @(posedge pclk or negedge clear_b) begin
    if (!clear_b) begin
      clk_sync <= '0;
      fss_sync <= '0;
      rxd_sync <= '0;
      clk_prev <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], sspclkin};
      fss_sync <= {fss_sync[SYNC_STAGES-2:0], sspfssin};
      rxd_sync <= {rxd_sync[SYNC_STAGES-2:0], ssprxd};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall  = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign fss_s = fss_sync[SYNC_STAGES-1];
  assign rxd_s = rxd_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ssp_rx_ctrl.sv
// SSP receive sequencer: assembles MSB-first frames and pushes them into the RxFIFO
// through a one-byte holding register, flagging overrun when a byte must be dropped.
module ssp_rx_ctrl
  import ssp_rx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic          pclk,
  input  logic          clear_b,
  ssp_rx_ctrl_if.slave  bus
);

  localparam int unsigned      CNT_W    = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [DATA_W-2:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] hold_q;
  logic              hold_valid_q;
  logic              overrun_q;

  logic              fall, fss_s, rxd_s;
  logic [DATA_W-1:0] frame_c;
  logic              complete_c;
  logic              push_c;
  logic              keep_c;

  ssp_rx_ctrl_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .pclk     (pclk),
    .clear_b  (clear_b),
    .sspclkin (bus.sspclkin),
    .sspfssin (bus.sspfssin),
    .ssprxd   (bus.ssprxd),
    .fall     (fall),
    .fss_s    (fss_s),
    .rxd_s    (rxd_s)
  );

  // Byte as it stands once the current bit is shifted in.
  assign frame_c = {shreg_q, rxd_s};

  // Receive FSM; rxen low aborts, frame sync mid-frame restarts the count.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    complete_c = 1'b0;
    if (!bus.rxen) begin
      state_d = RX_IDLE;
    end else begin
      case (state_q)
        RX_IDLE: begin
          if (fall && fss_s) begin
            state_d  = RX_SHIFT;
            bitcnt_d = '0;
          end
        end
        RX_SHIFT: begin
          if (fall) begin
            if (fss_s) begin
              bitcnt_d = '0;
            end else begin
              shreg_d  = frame_c[DATA_W-2:0];
              bitcnt_d = bitcnt_q + CNT_W'(1);
              if (bitcnt_q == LAST_BIT) begin
                state_d    = RX_IDLE;
                complete_c = 1'b1;
              end
            end
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge clear_b) begin
    if (!clear_b) begin
      state_q  <= RX_IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
    end
  end

  // Hold stays occupied unless it drains this cycle; a frame landing on an occupied hold is dropped.
  assign push_c = hold_valid_q & ~bus.rxfull;
  assign keep_c = hold_valid_q & ~push_c;

  always_ff @(posedge pclk or negedge clear_b) begin
    if (!clear_b) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (complete_c && !keep_c) begin
        hold_q <= frame_c;
      end
      hold_valid_q <= complete_c | keep_c;
      if (complete_c && keep_c) begin
        overrun_q <= 1'b1;
      end else if (bus.ovr_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.rcv       = push_c;
  assign bus.rxdata    = hold_q;
  assign bus.rxoverrun = overrun_q;
  assign bus.rxbusy    = (state_q == RX_SHIFT) | hold_valid_q;

endmodule
